// File: rtl/ram_pkg.sv
// Shared encodings for the toggle-protocol RAM bank.
package ram_pkg;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Wait-state counter width (WAIT_STATES range 0..15).
  localparam int unsigned WAIT_W = 4;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

endpackage

// File: rtl/toggle_sync.sv
// Synchronises a request toggle and turns each transition into a one-cycle pulse.
module toggle_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_toggle,
  output logic o_req
);

  logic w_sync;
  logic r_prev;

  generate
    if (STAGES == 0) begin : g_nosync
      assign w_sync = i_toggle;
    end else begin : g_sync
      logic [STAGES-1:0] r_sync;
      logic [STAGES:0]   w_shift;

      assign w_shift = {r_sync, i_toggle};
      assign w_sync  = r_sync[STAGES-1];

      // Synchroniser chain; reset preloads the live level so no request follows reset.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_sync <= {STAGES{i_toggle}};
        else          r_sync <= w_shift[STAGES-1:0];
      end
    end
  endgenerate

  // Previous synchronised level; always tracks, so a toggle is never replayed.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_prev <= i_toggle;
    else          r_prev <= w_sync;
  end

  assign o_req = w_sync ^ r_prev;

endmodule

// File: rtl/ram_toggle_bank.sv
// Single-port RAM bank driven by a two-phase toggle request / level ready protocol.
module ram_toggle_bank
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clkIn,
  input  logic                resetNIn,
  input  logic                triggerIn,
  input  logic                rwIn,
  input  logic [ADDR_W-1:0]   addrIn,
  input  logic [DATA_W-1:0]   dataIn,
  input  logic [DATA_W/8-1:0] byteEnIn,
  output logic [DATA_W-1:0]   dataOut,
  output logic                readyOut,
  output logic                ackOut,
  output logic                errorOut,
  output logic                overrunOut
);

  localparam int unsigned     LANES     = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic                w_req;
  logic                w_accept;
  logic                w_done;
  logic                w_oor;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [LANES-1:0]    r_be;
  logic [WAIT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_dout;
  logic                r_ack;
  logic                r_err;
  logic                r_ovr;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  toggle_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk    (clkIn),
    .i_rst_n  (resetNIn),
    .i_toggle (triggerIn),
    .o_req    (w_req)
  );

  assign w_oor = {1'b0, r_addr} >= DEPTH_LIM;

  // Next-state logic: accept in IDLE, complete in BUSY once the wait counter is spent.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clkIn) begin
    if (!resetNIn) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Request capture at acceptance and wait-state countdown while busy.
  always_ff @(posedge clkIn) begin
    if (!resetNIn) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_rw    <= rwIn;
      r_addr  <= addrIn;
      r_wdata <= dataIn;
      r_be    <= byteEnIn;
      r_cnt   <= WAIT_W'(WAIT_STATES);
    end else if (r_state == BUSY && r_cnt != '0) begin
      r_cnt <= r_cnt - WAIT_W'(1);
    end
  end

  // Byte-lane memory write; reset gating aborts a write caught mid-access.
  always_ff @(posedge clkIn) begin
    if (resetNIn && w_done && r_rw == RW_WRITE && !w_oor) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (r_be[i]) r_mem[r_addr][i*8 +: 8] <= r_wdata[i*8 +: 8];
      end
    end
  end

  // Read data register: holds the last completed read, zero when out of range.
  always_ff @(posedge clkIn) begin
    if (!resetNIn) begin
      r_dout <= '0;
    end else if (w_done && r_rw == RW_READ) begin
      r_dout <= w_oor ? '0 : r_mem[r_addr];
    end
  end

  // Completion status: ack toggle, range error, sticky overrun.
  always_ff @(posedge clkIn) begin
    if (!resetNIn) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (w_done) begin
        r_ack <= ~r_ack;
        r_err <= w_oor;
      end
      if (r_state == BUSY && w_req) r_ovr <= 1'b1;
    end
  end

  assign readyOut   = (r_state == IDLE);
  assign dataOut    = r_dout;
  assign ackOut     = r_ack;
  assign errorOut   = r_err;
  assign overrunOut = r_ovr;

endmodule

// File: tb/tb_ram_toggle_bank.sv
// Scoreboard bench: requests push expected completions, a monitor checks each ack.
module tb_ram_toggle_bank;

  localparam int unsigned S     = 2;
  localparam int unsigned W     = 5;
  localparam int unsigned DEPTH = 1000;
  localparam int unsigned LAT   = S + 2 + W;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig  = 1'b1;
  logic        rw    = 1'b0;
  logic [9:0]  addr  = '0;
  logic [31:0] din   = '0;
  logic [3:0]  be    = '0;
  logic [31:0] dout;
  logic        ready;
  logic        ack;
  logic        err;
  logic        ovr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc      = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic ack_seen = 1'b0;

  ram_toggle_bank #(
    .DATA_W      (32),
    .ADDR_W      (10),
    .DEPTH       (DEPTH),
    .WAIT_STATES (W),
    .SYNC_STAGES (S)
  ) dut (
    .clkIn      (clk),
    .resetNIn   (rst_n),
    .triggerIn  (trig),
    .rwIn       (rw),
    .addrIn     (addr),
    .dataIn     (din),
    .byteEnIn   (be),
    .dataOut    (dout),
    .readyOut   (ready),
    .ackOut     (ack),
    .errorOut   (err),
    .overrunOut (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      ack_seen = ack;
    end else if (ack !== ack_seen) begin
      ack_seen = ack;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ack: ackOut toggled at cycle %0d, expected no completion", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("ack_latency", cyc, mon_e.due);
        check("dataOut", dout, mon_e.data);
        check("errorOut", {31'b0, err}, {31'b0, mon_e.err});
      end
    end
  end

  // Issue one request; inject > 0 adds a second toggle that many busy cycles in.
  task automatic req(input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] b,
                     input logic [31:0] exp_d, input logic exp_e, input int unsigned inject);
    int unsigned low   = 0;
    int unsigned guard = 0;
    @(posedge clk); #2;
    rw = w; addr = a; din = d; be = b;
    trig = ~trig;
    sb.push_back('{exp_d, exp_e, cyc + LAT});
    while (ready && guard < 50) begin @(negedge clk); guard++; end
    while (!ready && guard < 100) begin
      low++;
      if (inject != 0 && low == inject) begin #1 trig = ~trig; end
      @(negedge clk);
      guard++;
    end
    check("busy_cycles", low, W + 1);
  endtask

  initial begin
    int unsigned low;
    int unsigned guard;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'b0, ready}, 32'd1);
    check("reset_ack", {31'b0, ack}, 32'd0);
    check("reset_dout", dout, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    check("reset_ovr", {31'b0, ovr}, 32'd0);
    low = 0;
    repeat (20) begin @(negedge clk); if (!ready) low++; end
    check("idle_after_reset", low, 0);
    check("idle_ack", {31'b0, ack}, 32'd0);

    req(1'b1, 10'd0,    32'hCAFEF00D, 4'hF, 32'h00000000, 1'b0, 0);
    req(1'b1, 10'd2,    32'd31,       4'hF, 32'h00000000, 1'b0, 0);
    req(1'b0, 10'd2,    32'h0,        4'h0, 32'd31,       1'b0, 0);
    req(1'b1, 10'd5,    32'hAABBCCDD, 4'hF, 32'd31,       1'b0, 0);
    req(1'b1, 10'd5,    32'h11223344, 4'h5, 32'd31,       1'b0, 0);
    req(1'b0, 10'd5,    32'h0,        4'h0, 32'hAA22CC44, 1'b0, 0);
    req(1'b1, 10'd9,    32'h12345678, 4'hF, 32'hAA22CC44, 1'b0, 2);
    repeat (10) @(negedge clk);
    check("overrun_set", {31'b0, ovr}, 32'd1);
    req(1'b0, 10'd9,    32'h0,        4'h0, 32'h12345678, 1'b0, 0);
    req(1'b1, 10'd999,  32'h0BADBEEF, 4'hF, 32'h12345678, 1'b0, 0);
    req(1'b0, 10'd999,  32'h0,        4'h0, 32'h0BADBEEF, 1'b0, 0);
    req(1'b1, 10'd1000, 32'hFFFFFFFF, 4'hF, 32'h0BADBEEF, 1'b1, 0);
    req(1'b0, 10'd1000, 32'h0,        4'h0, 32'h00000000, 1'b1, 0);
    req(1'b0, 10'd0,    32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 0);
    req(1'b1, 10'd7,    32'h77777777, 4'hF, 32'hCAFEF00D, 1'b0, 0);
    req(1'b0, 10'd7,    32'h0,        4'h0, 32'h77777777, 1'b0, 0);
    repeat (30) @(negedge clk);
    check("overrun_sticky", {31'b0, ovr}, 32'd1);
    check("scoreboard_drained", sb.size(), 0);

    // Write to addr 7 aborted by reset while busy.
    @(posedge clk); #2;
    rw = 1'b1; addr = 10'd7; din = 32'h0; be = 4'hF;
    trig = ~trig;
    guard = 0;
    while (ready && guard < 50) begin @(negedge clk); guard++; end
    check("abort_accepted", {31'b0, ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", {31'b0, ready}, 32'd1);
    check("abort_ack", {31'b0, ack}, 32'd0);
    check("abort_dout", dout, 32'd0);
    check("abort_ovr", {31'b0, ovr}, 32'd0);
    repeat (20) @(negedge clk);
    check("abort_no_ack", {31'b0, ack}, 32'd0);
    req(1'b0, 10'd7,    32'h0,        4'h0, 32'h77777777, 1'b0, 0);
    repeat (15) @(negedge clk);
    check("final_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
